mem_stage: RTL

Memory-access pipeline stage sitting directly downstream of the execute stage and upstream of register writeback. It takes one executed instruction per handshake and performs the required action:
- ALU results pass through to writeback.
- Single loads and stores go to data memory.
- Load-multiple (LM) and store-multiple (SM) run as a sequenced burst, one register per memory transfer, with the stage stalling upstream until the burst completes.

---
 rtl/mem_stage_pkg.sv | 19 +
 rtl/priority_encoder8.sv | 20 ++
 rtl/mem_stage.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory-access pipeline stage: opcodes, FSM states and
// default datapath widths.
package mem_stage_pkg;

    localparam int unsigned DATA_W_DEFAULT  = 16;
    localparam int unsigned REG_CNT_DEFAULT = 8;

    localparam logic [2:0] OP_ALU = 3'd0;
    localparam logic [2:0] OP_LW  = 3'd1;
    localparam logic [2:0] OP_SW  = 3'd2;
    localparam logic [2:0] OP_LM  = 3'd3;
    localparam logic [2:0] OP_SM  = 3'd4;

    typedef enum logic [0:0] {
        StIdle = 1'b0,
        StXfer = 1'b1
    } state_e;

endpackage

// File: rtl/priority_encoder8.sv
// Lowest-set-bit encoder for an 8-bit vector; none_o flags an all-zero input.
module priority_encoder8 (
    input  logic [7:0] vec_i,
    output logic [2:0] idx_o,
    output logic       none_o
);

    always_comb begin
        idx_o  = 3'd0;
        none_o = 1'b1;
        // Scan downward so the lowest set bit is the last one written.
        for (int i = 7; i >= 0; i--) begin
            if (vec_i[i]) begin
                idx_o  = i[2:0];
                none_o = 1'b0;
            end
        end
    end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: ALU pass-through, single LW/SW, and LM/SM bursts sequenced one
// register per memory transfer in ascending register order.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int unsigned DATA_W  = DATA_W_DEFAULT,
    parameter int unsigned REG_CNT = REG_CNT_DEFAULT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               inValid,
    output logic               inReady,
    input  logic [2:0]         inOp,
    input  logic [DATA_W-1:0]  inAddr,
    input  logic [DATA_W-1:0]  inData,
    input  logic [2:0]         inDest,
    input  logic               inRegWrite,
    input  logic [REG_CNT-1:0] inMask,
    output logic               memReq,
    output logic               memWe,
    output logic [DATA_W-1:0]  memAddr,
    output logic [DATA_W-1:0]  memWdata,
    input  logic               memReady,
    input  logic [DATA_W-1:0]  memRdata,
    output logic [2:0]         rfReadAddr,
    input  logic [DATA_W-1:0]  rfReadData,
    output logic               wbValid,
    output logic [2:0]         wbDest,
    output logic [DATA_W-1:0]  wbData,
    output logic               busy
);

    state_e             state_q, state_d;
    logic [DATA_W-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic [2:0]         dest_q, dest_d;
    logic [2:0]         op_q, op_d;
    logic [REG_CNT-1:0] mask_q, mask_d;
    logic               wb_valid_q, wb_valid_d;
    logic [2:0]         wb_dest_q, wb_dest_d;
    logic [DATA_W-1:0]  wb_data_q, wb_data_d;

    logic [2:0]         cur_idx;
    logic               cur_none;
    logic [REG_CNT-1:0] mask_clr;
    logic [2:0]         unused_rest_idx;
    logic               rest_none;
    logic               is_burst;

    priority_encoder8 u_cur_enc (
        .vec_i  (mask_q),
        .idx_o  (cur_idx),
        .none_o (cur_none)
    );

    // Looks at the mask with the current bit removed to spot the last transfer.
    priority_encoder8 u_rest_enc (
        .vec_i  (mask_clr),
        .idx_o  (unused_rest_idx),
        .none_o (rest_none)
    );

    assign mask_clr = mask_q & ~(REG_CNT'(1) << cur_idx);
    assign is_burst = (op_q == OP_LM) || (op_q == OP_SM);

    assign inReady    = (state_q == StIdle);
    assign busy       = (state_q == StXfer);
    assign memReq     = (state_q == StXfer);
    assign memWe      = memReq && ((op_q == OP_SW) || (op_q == OP_SM));
    assign memAddr    = addr_q;
    assign memWdata   = (op_q == OP_SM) ? rfReadData : data_q;
    assign rfReadAddr = cur_idx;
    assign wbValid    = wb_valid_q;
    assign wbDest     = wb_dest_q;
    assign wbData     = wb_data_q;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        data_d     = data_q;
        dest_d     = dest_q;
        op_d       = op_q;
        mask_d     = mask_q;
        wb_valid_d = 1'b0;
        wb_dest_d  = wb_dest_q;
        wb_data_d  = wb_data_q;

        case (state_q)
            StIdle: begin
                if (inValid) begin
                    case (inOp)
                        OP_ALU: begin
                            if (inRegWrite) begin
                                wb_valid_d = 1'b1;
                                wb_dest_d  = inDest;
                                wb_data_d  = inAddr;
                            end
                        end
                        OP_LW, OP_SW: begin
                            addr_d  = inAddr;
                            data_d  = inData;
                            dest_d  = inDest;
                            op_d    = inOp;
                            state_d = StXfer;
                        end
                        OP_LM, OP_SM: begin
                            if (|inMask) begin
                                addr_d  = inAddr;
                                mask_d  = inMask;
                                op_d    = inOp;
                                state_d = StXfer;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            StXfer: begin
                if (memReady) begin
                    if (op_q == OP_LW) begin
                        wb_valid_d = 1'b1;
                        wb_dest_d  = dest_q;
                        wb_data_d  = memRdata;
                    end else if (op_q == OP_LM) begin
                        wb_valid_d = 1'b1;
                        wb_dest_d  = cur_idx;
                        wb_data_d  = memRdata;
                    end
                    if (is_burst) begin
                        mask_d = mask_clr;
                        addr_d = addr_q + DATA_W'(1);
                        if (rest_none || cur_none) begin
                            state_d = StIdle;
                        end
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            addr_q     <= '0;
            data_q     <= '0;
            dest_q     <= '0;
            op_q       <= '0;
            mask_q     <= '0;
            wb_valid_q <= 1'b0;
            wb_dest_q  <= '0;
            wb_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            dest_q     <= dest_d;
            op_q       <= op_d;
            mask_q     <= mask_d;
            wb_valid_q <= wb_valid_d;
            wb_dest_q  <= wb_dest_d;
            wb_data_q  <= wb_data_d;
        end
    end

endmodule
